// File: rtl/gray_encoder_stream.sv
`default_nettype none
// ============================================================================
// Module   : gray_encoder_stream
// Purpose  : Streaming binary-to-Gray encoder. Words are encoded on entry
//            (gray = bin ^ (bin >> 1)) and buffered in a 2-entry FIFO.
//            The FIFO has valid/ready handshakes on both sides and a
//            wrapping count of completed output transfers.
// Options  : GRAY_STEP_CHECK_EN - when defined, each popped word is
//            compared with the previously popped one. If they differ in
//            anything other than exactly one bit, the sticky step_err
//            flag is set.
// Revision : 1.0 - initial release
// ============================================================================
module gray_encoder_stream #(
   parameter int W  = 8,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_gray,
   output logic [CW-1:0] xfer_cnt,
   output logic          step_err
);

   // Occupancy encoding of the two-entry buffer
   localparam logic [1:0] C_OCC_EMPTY = 2'd0;
   localparam logic [1:0] C_OCC_ONE   = 2'd1;
   localparam logic [1:0] C_OCC_FULL  = 2'd2;

   logic [1:0]    occ_q,  occ_d;
   logic [W-1:0]  head_q, head_d;
   logic [W-1:0]  tail_q, tail_d;
   logic [CW-1:0] cnt_q,  cnt_d;

   logic          w_push;
   logic          w_pop;
   logic [W-1:0]  w_enc;

   // Handshakes and encoding.
   // in_ready is derived only from registered occupancy and reset,
   // never from out_ready.
   assign in_ready  = (occ_q != C_OCC_FULL) && rst_n;
   assign out_valid = (occ_q != C_OCC_EMPTY);
   assign out_gray  = head_q;
   assign xfer_cnt  = cnt_q;
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;
   assign w_enc     = in_data ^ (in_data >> 1);

   // FIFO next state: the head register always holds the oldest word.
   // When the buffer empties, the head keeps the last popped value.
   always_comb begin
      occ_d  = occ_q;
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      case ({w_push, w_pop})
         2'b10: begin
            if (occ_q == C_OCC_EMPTY) begin
               head_d = w_enc;
            end else begin
               tail_d = w_enc;
            end
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            if (occ_q == C_OCC_FULL) begin
               head_d = tail_q;
            end
            occ_d = occ_q - 2'd1;
         end
         2'b11: begin
            // Only reachable at occupancy one: the new word replaces the head
            head_d = w_enc;
         end
         default: begin
         end
      endcase
      if (w_pop) begin
         cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         occ_q  <= C_OCC_EMPTY;
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         occ_q  <= occ_d;
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   // Keep tail visible as used when only one slot ever fills
   logic w_unused_one;
   assign w_unused_one = (occ_q == C_OCC_ONE);

`ifdef GRAY_STEP_CHECK_EN
   logic [W-1:0] prev_q, prev_d;
   logic         hist_q, hist_d;
   logic         err_q,  err_d;
   logic [W-1:0] w_diff;
   logic         w_onehot;

   // A legal Gray step differs in exactly one bit: non-zero and a power of two
   assign w_diff   = head_q ^ prev_q;
   assign w_onehot = (w_diff != '0) && ((w_diff & (w_diff - {{(W-1){1'b0}}, 1'b1})) == '0);
   assign step_err = err_q;

   // Step-check next state: remember each popped word and flag bad steps
   always_comb begin
      prev_d = prev_q;
      hist_d = hist_q;
      err_d  = err_q;
      if (w_pop) begin
         prev_d = head_q;
         hist_d = 1'b1;
         if (hist_q && !w_onehot) begin
            err_d = 1'b1;
         end
      end
   end

   // Step-check history registers; only reset clears the sticky flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_q <= '0;
         hist_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         prev_q <= prev_d;
         hist_q <= hist_d;
         err_q  <= err_d;
      end
   end
`else
   assign step_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_encoder_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_encoder_stream
// Purpose  : Self-checking bench for gray_encoder_stream. Stimulus is a
//            directed sequence. Expected Gray words are queued when accepted
//            and compared against the DUT when they are popped.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gray_encoder_stream;
   localparam int W  = 8;
   localparam int CW = 4;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_gray;
   logic [CW-1:0] xfer_cnt;
   logic          step_err;

   gray_encoder_stream #(.W(W), .CW(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_gray  (out_gray),
      .xfer_cnt  (xfer_cnt),
      .step_err  (step_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Scoreboard and reference state
   logic [W-1:0]  sb_q[$];
   logic [W-1:0]  m_last;
   logic [CW-1:0] m_cnt;
   logic          m_err;
   logic          m_hist;
   logic [W-1:0]  m_prev;

   function automatic logic [W-1:0] enc(input logic [W-1:0] b);
      logic [W-1:0] g;
      g[W-1] = b[W-1];
      for (int i = 0; i < W-1; i++) g[i] = b[i+1] ^ b[i];
      return g;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      sb_q.delete();
      m_last = '0;
      m_cnt  = '0;
      m_err  = 1'b0;
      m_hist = 1'b0;
      m_prev = '0;
   endtask

   // One clock: drive inputs, check outputs against the model, advance model
   task automatic step(input logic v, input logic [W-1:0] d, input logic r, input logic rn);
      logic          push;
      logic          pop;
      logic [W-1:0]  g;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      rst_n     = rn;
      #1;
      check("out_valid", {31'd0, out_valid}, {31'd0, (sb_q.size() > 0)});
      check("in_ready",  {31'd0, in_ready},  {31'd0, (sb_q.size() < 2) && rn});
      check("out_gray",  32'(out_gray), 32'((sb_q.size() > 0) ? sb_q[0] : m_last));
      check("xfer_cnt",  32'(xfer_cnt), 32'(m_cnt));
      check("step_err",  {31'd0, step_err}, {31'd0, m_err});
      push = v && rn && (sb_q.size() < 2);
      pop  = r && rn && (sb_q.size() > 0);
      @(posedge clk);
      if (!rn) begin
         model_reset();
      end else begin
         if (pop) begin
            g      = sb_q.pop_front();
            m_last = g;
            m_cnt  = m_cnt + 1'b1;
`ifdef GRAY_STEP_CHECK_EN
            if (m_hist && $countones(g ^ m_prev) != 1) m_err = 1'b1;
            m_hist = 1'b1;
            m_prev = g;
`endif
         end
         if (push) sb_q.push_back(enc(d));
      end
      @(negedge clk);
   endtask

   initial begin
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Reset state
      step(1'b0, 8'h00, 1'b0, 1'b1);

      // Test 1: basic encode with out_ready held high
      step(1'b1, 8'h05, 1'b1, 1'b1);
      check("t1_g0", 32'(out_gray), 32'h07);
      step(1'b1, 8'h80, 1'b1, 1'b1);
      check("t1_g1", 32'(out_gray), 32'hC0);
      step(1'b1, 8'hFF, 1'b1, 1'b1);
      check("t1_g2", 32'(out_gray), 32'h80);
      step(1'b1, 8'h0F, 1'b1, 1'b1);
      check("t1_g3", 32'(out_gray), 32'h08);
      step(1'b0, 8'hAA, 1'b1, 1'b1);
      check("t1_cnt", 32'(xfer_cnt), 32'd4);

      // Test 2: backpressure fills the FIFO, third word waits
      step(1'b1, 8'h01, 1'b0, 1'b1);
      step(1'b1, 8'h02, 1'b0, 1'b1);
      step(1'b1, 8'h03, 1'b0, 1'b1);
      check("t2_full_rdy", {31'd0, in_ready}, 32'd0);
      check("t2_hold", 32'(out_gray), 32'h01);
      step(1'b1, 8'h03, 1'b1, 1'b1);
      step(1'b1, 8'h03, 1'b1, 1'b1);
      step(1'b0, 8'h00, 1'b1, 1'b1);
      step(1'b0, 8'h00, 1'b1, 1'b1);

      // Test 3: ten simultaneous push+pop at occupancy one
      step(1'b1, 8'h10, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h11 + i), 1'b1, 1'b1);
      step(1'b0, 8'h00, 1'b1, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1);

      // Test 4: reset with a full FIFO discards both words
      step(1'b1, 8'h3C, 1'b0, 1'b1);
      step(1'b1, 8'h5A, 1'b0, 1'b1);
      step(1'b1, 8'h77, 1'b1, 1'b0);
      check("t4_valid", {31'd0, out_valid}, 32'd0);
      check("t4_gray", 32'(out_gray), 32'd0);
      check("t4_cnt", 32'(xfer_cnt), 32'd0);
      step(1'b0, 8'h00, 1'b1, 1'b1);

      // Test 5: 17 pops wrap the 4-bit counter to 1
      for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 1'b1, 1'b1);
      step(1'b0, 8'h00, 1'b1, 1'b1);
      check("t5_wrap", 32'(xfer_cnt), 32'd1);

      // Test 6: Gray-step checking (0,1,2,3 legal, then 5 is a two-bit jump)
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b1, 8'h00, 1'b1, 1'b1);
      step(1'b1, 8'h01, 1'b1, 1'b1);
      step(1'b1, 8'h02, 1'b1, 1'b1);
      step(1'b1, 8'h03, 1'b1, 1'b1);
      step(1'b1, 8'h05, 1'b1, 1'b1);
      check("t6_clean", {31'd0, step_err}, 32'd0);
      step(1'b0, 8'h00, 1'b1, 1'b1);
      step(1'b0, 8'h00, 1'b1, 1'b1);
`ifdef GRAY_STEP_CHECK_EN
      check("t6_sticky", {31'd0, step_err}, 32'd1);
`else
      check("t6_tied", {31'd0, step_err}, 32'd0);
`endif
      step(1'b0, 8'h00, 1'b0, 1'b0);
      check("t6_rst", {31'd0, step_err}, 32'd0);
      step(1'b0, 8'h00, 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/gray_encoder_stream.md
Name: gray_encoder_stream

Overview:
Streaming binary-to-Gray encoder; the transmit-side counterpart of the team's Gray-to-binary decoder.
- Accepts binary words on a valid/ready input, computes gray = bin ^ (bin >> 1), and presents the result through a 2-entry output FIFO with valid/ready.
- Counts completed output transfers.
- Sits between a binary position/pointer source and the Gray-coded bus that the decoder consumes.

Parameters:
W, 8, data width in bits (W >= 2)
CW, 16, width of the transfer counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset; synchronous, active-low
in_valid  input  1  binary word present on in_data
in_ready  output  1  block can accept a word this cycle
in_data  input  W  binary word
out_valid  output  1  Gray word present on out_gray
out_ready  input  1  downstream accepts out_gray this cycle
out_gray  output  W  Gray-coded word (FIFO head)
xfer_cnt  output  CW  number of completed output transfers, modulo 2^CW
step_err  output  1  sticky Gray-step violation flag (see Optional Feature)

Behaviour:
- Reset is synchronous, active-low, one clock, sampled on the rising clk edge.
- While rst_n=0 at an edge, the next state is: FIFO empty, out_valid=0, out_gray=0, xfer_cnt=0, step_err=0, check history invalid.
- in_ready=0 whenever rst_n=0.
- Encode rule: gray[W-1]=bin[W-1]; gray[i]=bin[i+1]^bin[i] for i<W-1. Pure bitwise; no carry; no width growth.
- Encoding is done at push time. FIFO entries store Gray words. out_gray is driven from the head register with no combinational path from in_data.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (occupancy < 2) && rst_n. It depends only on registered occupancy, never on out_ready. There is no combinational in→out or out_ready→in_ready path.
- out_valid = (occupancy > 0), registered.
- Latency: a word pushed at edge N is visible on out_gray with out_valid=1 after edge N, provided the FIFO was empty. Otherwise it appears after the words ahead of it are popped.
- Ordering is strict FIFO.
- Occupancy transitions:
  - 0: push → 1.
  - 1: push only → 2; pop only → 0; push+pop same edge → stays 1, head becomes the new word.
  - 2: pop → 1; no push is possible because in_ready=0.
- out_gray holds its value while out_valid=1 and out_ready=0; the head must not change until popped.
- When empty, out_gray holds the last popped value (0 after reset). Downstream must ignore it while out_valid=0.
- xfer_cnt increments by 1 on every pop and wraps from 2^CW-1 to 0.
- in_data is ignored when in_valid=0. out_ready is ignored when out_valid=0 and does not increment xfer_cnt.
- Reset mid-operation: buffered words are discarded, not output. The counter clears. Outputs are at reset values on the first cycle after the reset edge.

Optional Feature:
Macro GRAY_STEP_CHECK_EN.
- Defined: the block keeps the last popped Gray word and a history-valid bit.
  - On each pop with history valid, step_err is set if popcount(new ^ previous) != 1.
  - step_err is sticky and cleared only by reset.
  - The first pop after reset sets history valid and never flags.
- Not defined: step_err is tied to 0 and no history registers exist. The port list is unchanged.

Test Plan:
1. Basic encode, out_ready=1 held: push 0x05, 0x80, 0xFF, 0x0F (W=8) → out_gray 0x07, 0xC0, 0x80, 0x08 in order, each one cycle after push; xfer_cnt=4.
2. Backpressure: out_ready=0, drive in_valid=1 with 0x01, 0x02, 0x03 → first two accepted, in_ready=0 after the second, out_gray holds 0x01. Raise out_ready → outputs 0x01, 0x03 (Gray of 0x01, 0x02); 0x03 is then accepted and yields 0x02.
3. Simultaneous push+pop at occupancy 1 for 10 cycles with an incrementing binary input → occupancy stays 1, one output per cycle, xfer_cnt +10.
4. Reset mid-operation: FIFO full, assert rst_n=0 for one edge → out_valid=0, out_gray=0, xfer_cnt=0, in_ready=0 during reset and 1 the cycle after release; the discarded words never appear.
5. Counter wrap with CW=4: 17 pops → xfer_cnt=1.
6. With GRAY_STEP_CHECK_EN: binary sequence 0,1,2,3 → step_err stays 0; then 0x05 after 3 (Gray 0x02→0x07, 2 bits differ) → step_err=1 and remains 1 until reset. Without the macro, the same stimulus gives step_err=0 throughout.
